// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/exec AXI memory arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WRITE,
        WRESP,
        DONE
    } state_e;

    localparam logic       SZ_BYTE    = 1'b0;
    localparam logic       SZ_WORD    = 1'b1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_DEF  = 4'b0011;
    localparam logic       LOCK_DEF   = 1'b0;
    localparam logic [2:0] PROT_DEF   = 3'b000;
    localparam logic [3:0] QOS_DEF    = 4'b0000;
    localparam logic [2:0] ARSIZE_B   = 3'b000;
    localparam logic [2:0] ARSIZE_W   = 3'b010;

    function automatic logic [2:0] ax_size(input logic sz);
        return (sz == SZ_WORD) ? ARSIZE_W : ARSIZE_B;
    endfunction

endpackage

// File: rtl/axi_lane_mux.sv
// Combinational lane steering between a 32-bit requester word and the 512-bit AXI data bus.
module axi_lane_mux
    import mem_arb_pkg::*;
(
    input  logic [511:0] rdata,
    input  logic [5:0]   addr,
    input  logic         size,
    input  logic [31:0]  wdata_in,
    output logic [31:0]  rword,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb
);

    logic [31:0] lane_word;
    logic [7:0]  lane_byte;

    always_comb begin
        lane_word = rdata[32*addr[5:2] +: 32];
        lane_byte = rdata[8*addr +: 8];
        if (size == SZ_WORD) begin
            rword = lane_word;
            wdata = {16{wdata_in}};
            wstrb = 64'hf << {addr[5:2], 2'b00};
        end else begin
            // byte stores come from [7:0] so every byte lane carries the same byte
            rword = {{24{lane_byte[7]}}, lane_byte};
            wdata = {64{wdata_in[7:0]}};
            wstrb = 64'h1 << addr;
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Fetch/exec arbiter onto one AXI4 master port; one single-beat transaction outstanding at a time.
// Define ARB_RR_EN for round-robin arbitration (default: fixed exec-over-fetch priority).
module axi_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [3:0] FETCH_ID = 4'h0,
    parameter logic [3:0] EXEC_ID  = 4'h1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         f_req,
    input  logic [30:0]  f_addr,
    output logic         f_ack,
    output logic [31:0]  f_rdata,
    input  logic         e_req,
    input  logic         e_we,
    input  logic         e_size,
    input  logic [30:0]  e_addr,
    input  logic [31:0]  e_wdata,
    output logic         e_ack,
    output logic [31:0]  e_rdata,
    output logic         e_err,
    output logic [30:0]  araddr,
    output logic [3:0]   arid,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [3:0]   arcache,
    output logic         arlock,
    output logic [2:0]   arprot,
    output logic [3:0]   arqos,
    output logic         arvalid,
    input  logic         arready,
    input  logic [511:0] rdata,
    input  logic [3:0]   rid,
    input  logic         rlast,
    input  logic [1:0]   rresp,
    input  logic         rvalid,
    output logic         rready,
    output logic [30:0]  awaddr,
    output logic [3:0]   awid,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [3:0]   awcache,
    output logic         awlock,
    output logic [2:0]   awprot,
    output logic [3:0]   awqos,
    output logic         awvalid,
    input  logic         awready,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    state_e      state_q, state_d;
    logic        sel_exec_q, sel_exec_d;
    logic [30:0] addr_q, addr_d;
    logic        size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        f_ack_q, f_ack_d;
    logic        e_ack_q, e_ack_d;
    logic        e_err_q, e_err_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] e_rdata_q, e_rdata_d;

    logic        pick_exec;
    logic        rd_fire;
    logic        aw_done;
    logic        w_done;
    logic [31:0] rword;
    logic [511:0] mux_wdata;
    logic [63:0] mux_wstrb;

    // rid/bid/rlast carry no information for single-beat, single-outstanding traffic
    logic unused_ok;
    assign unused_ok = ^{rid, rlast, bid, f_addr[1:0]};

    axi_lane_mux u_lane_mux (
        .rdata    (rdata),
        .addr     (addr_q[5:0]),
        .size     (size_q),
        .wdata_in (wdata_q),
        .rword    (rword),
        .wdata    (mux_wdata),
        .wstrb    (mux_wstrb)
    );

`ifdef ARB_RR_EN
    logic last_exec_q, last_exec_d;

    always_comb begin
        pick_exec   = e_req && (!f_req || !last_exec_q);
        last_exec_d = last_exec_q;
        if (state_q == IDLE && (f_req || e_req)) last_exec_d = pick_exec;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_exec_q <= 1'b0;
        else       last_exec_q <= last_exec_d;
    end
`else
    always_comb pick_exec = e_req;
`endif

    always_comb begin
        state_d    = state_q;
        sel_exec_d = sel_exec_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        f_ack_d    = 1'b0;
        e_ack_d    = 1'b0;
        e_err_d    = 1'b0;
        f_rdata_d  = f_rdata_q;
        e_rdata_d  = e_rdata_q;
        aw_done    = !awvalid_q || awready;
        w_done     = !wvalid_q || wready;
        rd_fire    = rready_q && rvalid &&
                     ((state_q == RADDR && arready) || state_q == RDATA);

        case (state_q)
            IDLE: begin
                if (f_req || e_req) begin
                    sel_exec_d = pick_exec;
                    if (pick_exec) begin
                        addr_d  = (e_size == SZ_WORD) ? {e_addr[30:2], 2'b00} : e_addr;
                        size_d  = e_size;
                        wdata_d = e_wdata;
                    end else begin
                        addr_d  = {f_addr[30:2], 2'b00};
                        size_d  = SZ_WORD;
                    end
                    if (pick_exec && e_we) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end
            end
            RDATA: ;
            WRITE: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    e_ack_d  = 1'b1;
                    e_err_d  = (bresp != 2'b00);
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // read completion is shared by RDATA and the AR+R same-cycle case in RADDR
        if (rd_fire) begin
            rready_d = 1'b0;
            state_d  = DONE;
            if (sel_exec_q) begin
                e_ack_d   = 1'b1;
                e_err_d   = (rresp != 2'b00);
                e_rdata_d = rword;
            end else begin
                f_ack_d   = 1'b1;
                f_rdata_d = rword;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sel_exec_q <= 1'b0;
            addr_q     <= '0;
            size_q     <= SZ_WORD;
            wdata_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            f_ack_q    <= 1'b0;
            e_ack_q    <= 1'b0;
            e_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            e_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_exec_q <= sel_exec_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            f_ack_q    <= f_ack_d;
            e_ack_q    <= e_ack_d;
            e_err_q    <= e_err_d;
            f_rdata_q  <= f_rdata_d;
            e_rdata_q  <= e_rdata_d;
        end
    end

    assign f_ack   = f_ack_q;
    assign f_rdata = f_rdata_q;
    assign e_ack   = e_ack_q;
    assign e_rdata = e_rdata_q;
    assign e_err   = e_err_q;

    assign araddr  = addr_q;
    assign arid    = sel_exec_q ? EXEC_ID : FETCH_ID;
    assign arlen   = 8'd0;
    assign arsize  = ax_size(size_q);
    assign arburst = BURST_INCR;
    assign arcache = CACHE_DEF;
    assign arlock  = LOCK_DEF;
    assign arprot  = PROT_DEF;
    assign arqos   = QOS_DEF;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awaddr  = addr_q;
    assign awid    = EXEC_ID;
    assign awlen   = 8'd0;
    assign awsize  = ax_size(size_q);
    assign awburst = BURST_INCR;
    assign awcache = CACHE_DEF;
    assign awlock  = LOCK_DEF;
    assign awprot  = PROT_DEF;
    assign awqos   = QOS_DEF;
    assign awvalid = awvalid_q;
    assign wdata   = mux_wdata;
    assign wstrb   = wvalid_q ? mux_wstrb : 64'd0;
    assign wlast   = wvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: reactive AXI slave model plus an ack scoreboard.
module tb_axi_mem_arbiter;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         f_req = 1'b0;
    logic [30:0]  f_addr = '0;
    logic         f_ack;
    logic [31:0]  f_rdata;
    logic         e_req = 1'b0;
    logic         e_we = 1'b0;
    logic         e_size = 1'b1;
    logic [30:0]  e_addr = '0;
    logic [31:0]  e_wdata = '0;
    logic         e_ack;
    logic [31:0]  e_rdata;
    logic         e_err;
    logic [30:0]  araddr, awaddr;
    logic [3:0]   arid, awid, arcache, awcache, arqos, awqos;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize, arprot, awprot;
    logic [1:0]   arburst, awburst;
    logic         arlock, awlock;
    logic         arvalid, rready, awvalid, wvalid, wlast, bready;
    logic         arready = 1'b0;
    logic [511:0] rdata = '0;
    logic [3:0]   rid = '0;
    logic         rlast = 1'b0;
    logic [1:0]   rresp = '0;
    logic         rvalid = 1'b0;
    logic         awready = 1'b0;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wready = 1'b0;
    logic [3:0]   bid = '0;
    logic [1:0]   bresp = '0;
    logic         bvalid = 1'b0;

    axi_mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .e_req(e_req), .e_we(e_we), .e_size(e_size), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_ack(e_ack), .e_rdata(e_rdata), .e_err(e_err),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arcache(arcache), .arlock(arlock), .arprot(arprot), .arqos(arqos),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awcache(awcache), .awlock(awlock), .awprot(awprot), .awqos(awqos),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_exec;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
    } exp_t;
    exp_t sb_q[$];

    // slave configuration and observations
    int           ar_wait = 0, aw_wait = 0;
    logic [511:0] line = '0;
    logic [1:0]   rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    logic [30:0]  rec_araddr = '0, rec_awaddr = '0;
    logic [2:0]   rec_arsize = '0, rec_awsize = '0;
    logic [3:0]   rec_arid = '0, rec_awid = '0;
    logic [7:0]   rec_arlen = '0;
    logic [511:0] rec_wdata = '0;
    logic [63:0]  rec_wstrb = '0;
    logic         rec_wlast = 1'b0;
    int           ar_cyc = 0, b_cyc = 0;
    int           ar_cnt = 0, aw_cnt = 0;
    bit           r_pend = 0, aw_done = 0, w_done = 0;

    // Ready is raised only while valid is seen and held exactly one cycle, so every
    // raised ready (and every valid raised while the DUT's ready is high) is a handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; r_pend = 0; aw_done = 0; w_done = 0;
            end else begin
                if (arready) begin
                    arready = 0; r_pend = 1;
                end else if (arvalid) begin
                    if (ar_cnt == 0) ar_cyc = cyc;
                    if (ar_cnt >= ar_wait) begin
                        arready = 1; ar_cnt = 0;
                        rec_araddr = araddr; rec_arsize = arsize; rec_arid = arid; rec_arlen = arlen;
                    end else ar_cnt++;
                end
                if (rvalid) rvalid = 0;
                else if (r_pend && rready) begin
                    rvalid = 1; rdata = line; rresp = rresp_cfg; rid = rec_arid; rlast = 1; r_pend = 0;
                end
                if (awready) begin
                    awready = 0; aw_done = 1;
                end else if (awvalid) begin
                    if (aw_cnt >= aw_wait) begin
                        awready = 1; aw_cnt = 0;
                        rec_awaddr = awaddr; rec_awsize = awsize; rec_awid = awid;
                    end else aw_cnt++;
                end
                if (wready) begin
                    wready = 0; w_done = 1;
                end else if (wvalid) begin
                    wready = 1; rec_wdata = wdata; rec_wstrb = wstrb; rec_wlast = wlast;
                end
                if (bvalid) bvalid = 0;
                else if (aw_done && w_done && bready) begin
                    bvalid = 1; bresp = bresp_cfg; bid = rec_awid; b_cyc = cyc;
                    aw_done = 0; w_done = 0;
                end
            end
        end
    end

    task automatic fill_line();
        for (int i = 0; i < 16; i++) line[32*i +: 32] = $urandom;
    endtask

    // Drives one request and waits (bounded) for its ack; requester drops req on the ack.
    task automatic run_op(input bit is_exec, input bit we, input bit sz, input logic [30:0] addr,
                          input logic [31:0] wd, output bit ok, output logic [31:0] rd,
                          output bit err, output int t0, output int t_ack);
        @(negedge clk);
        if (is_exec) begin
            e_req = 1; e_we = we; e_size = sz; e_addr = addr; e_wdata = wd;
        end else begin
            f_req = 1; f_addr = addr;
        end
        t0 = cyc; ok = 0; rd = '0; err = 0; t_ack = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (is_exec ? e_ack : f_ack) begin
                ok = 1; rd = is_exec ? e_rdata : f_rdata; err = e_err; t_ack = cyc;
            end
        end
        f_req = 0; e_req = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arvalid, rready, awvalid, wvalid, wlast, bready} !== 6'b0) begin
            failures++; $display("FAIL reset_valids got=%b exp=000000", {arvalid, rready, awvalid, wvalid, wlast, bready});
        end
        checks++;
        if ({f_ack, e_ack, e_err} !== 3'b0 || f_rdata !== 32'd0 || e_rdata !== 32'd0) begin
            failures++; $display("FAIL reset_acks acks=%b f_rdata=%h e_rdata=%h exp 0", {f_ack, e_ack, e_err}, f_rdata, e_rdata);
        end
        checks++;
        if (araddr !== 31'd0 || awaddr !== 31'd0 || wdata !== 512'd0 || wstrb !== 64'd0) begin
            failures++; $display("FAIL reset_bus araddr=%h awaddr=%h wstrb=%h exp 0", araddr, awaddr, wstrb);
        end
        checks++;
        if ({arburst, arcache, arlock, arprot, arqos} !== {2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000} ||
            {awburst, awcache, awlock, awprot, awqos} !== {2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000}) begin
            failures++; $display("FAIL ax_consts ar=%h aw=%h", {arburst, arcache, arlock, arprot, arqos},
                                 {awburst, awcache, awlock, awprot, awqos});
        end
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        bit ok, err; logic [31:0] rd; int t0, ta; exp_t ex;
        fill_line(); line[31:0] = 32'hDEADBEEF; rresp_cfg = 2'b00; ar_wait = 0;
        sb_q.push_back('{0, 32'hDEADBEEF, 1, 0});
        run_op(0, 0, 1, 31'h100, 32'h0, ok, rd, err, t0, ta);
        ex = sb_q.pop_front();
        checks++;
        if (!ok) begin failures++; $display("FAIL fetch_timeout no f_ack"); end
        checks++;
        if (rd !== ex.data || err !== ex.err) begin
            failures++; $display("FAIL fetch_rdata got=%h err=%b exp=%h err=%b", rd, err, ex.data, ex.err);
        end
        checks++;
        if (ar_cyc - t0 !== 1 || ta - t0 !== 3) begin
            failures++; $display("FAIL fetch_latency ar=%0d ack=%0d exp ar=1 ack=3", ar_cyc - t0, ta - t0);
        end
        checks++;
        if (rec_araddr !== 31'h100 || rec_arsize !== 3'b010 || rec_arid !== 4'h0 || rec_arlen !== 8'd0) begin
            failures++; $display("FAIL fetch_ar addr=%h size=%b id=%h len=%h exp 100/010/0/0",
                                 rec_araddr, rec_arsize, rec_arid, rec_arlen);
        end
    endtask

    task automatic test_exec_loads();
        bit ok, err; logic [31:0] rd; int t0, ta; exp_t ex;
        logic [30:0] addrs [3];
        logic        szs   [3];
        logic [30:0] exp_ar[3];
        logic [2:0]  exp_sz[3];
        addrs = '{31'h47, 31'h13, 31'h4E};
        szs   = '{1'b0, 1'b0, 1'b1};
        exp_ar = '{31'h47, 31'h13, 31'h4C};
        exp_sz = '{3'b000, 3'b000, 3'b010};
        for (int k = 0; k < 3; k++) begin
            fill_line();
            case (k)
                0: begin line[8*7 +: 8] = 8'h80;         sb_q.push_back('{1, 32'hFFFFFF80, 1, 0}); end
                1: begin line[8*19 +: 8] = 8'h7F;        sb_q.push_back('{1, 32'h0000007F, 1, 0}); end
                default: begin line[32*3 +: 32] = 32'hA5A55A5A; sb_q.push_back('{1, 32'hA5A55A5A, 1, 0}); end
            endcase
            run_op(1, 0, szs[k], addrs[k], 32'h0, ok, rd, err, t0, ta);
            ex = sb_q.pop_front();
            checks++;
            if (!ok || rd !== ex.data || err !== ex.err) begin
                failures++; $display("FAIL load%0d_rdata ok=%b got=%h err=%b exp=%h err=%b", k, ok, rd, err, ex.data, ex.err);
            end
            checks++;
            if (rec_araddr !== exp_ar[k] || rec_arsize !== exp_sz[k] || rec_arid !== 4'h1) begin
                failures++; $display("FAIL load%0d_ar addr=%h size=%b id=%h exp %h/%b/1",
                                     k, rec_araddr, rec_arsize, rec_arid, exp_ar[k], exp_sz[k]);
            end
        end
    endtask

    task automatic test_store_word();
        bit ok, err; logic [31:0] rd; int t0, ta; exp_t ex;
        logic [511:0] exp_wd;
        exp_wd = {16{32'h12345678}};
        aw_wait = 3; bresp_cfg = 2'b00;
        sb_q.push_back('{1, 32'h0, 0, 0});
        run_op(1, 1, 1, 31'h48, 32'h12345678, ok, rd, err, t0, ta);
        aw_wait = 0;
        ex = sb_q.pop_front();
        checks++;
        if (!ok || err !== ex.err) begin
            failures++; $display("FAIL sw_ack ok=%b err=%b exp ok=1 err=%b", ok, err, ex.err);
        end
        checks++;
        if (rec_wstrb !== 64'h0000_0000_0000_0F00 || rec_wdata !== exp_wd || rec_wlast !== 1'b1) begin
            failures++; $display("FAIL sw_wdata wstrb=%h wlast=%b exp wstrb=0000000000000f00 wlast=1", rec_wstrb, rec_wlast);
        end
        checks++;
        if (rec_awaddr !== 31'h48 || rec_awsize !== 3'b010 || rec_awid !== 4'h1) begin
            failures++; $display("FAIL sw_aw addr=%h size=%b id=%h exp 48/010/1", rec_awaddr, rec_awsize, rec_awid);
        end
        checks++;
        if (ta !== b_cyc + 1) begin
            failures++; $display("FAIL sw_ack_timing ack=%0d bvalid=%0d exp ack=bvalid+1", ta, b_cyc);
        end
    endtask

    task automatic test_errors();
        bit ok, err; logic [31:0] rd; int t0, ta; exp_t ex;
        logic [511:0] exp_wd;
        exp_wd = {64{8'hAB}};
        bresp_cfg = 2'b10;
        sb_q.push_back('{1, 32'h0, 0, 1});
        run_op(1, 1, 0, 31'h05, 32'hFFFF12AB, ok, rd, err, t0, ta);
        bresp_cfg = 2'b00;
        ex = sb_q.pop_front();
        checks++;
        if (!ok || err !== ex.err || ta !== b_cyc + 1) begin
            failures++; $display("FAIL sb_err ok=%b err=%b ack=%0d bvalid=%0d exp err=1 ack=bvalid+1", ok, err, ta, b_cyc);
        end
        checks++;
        if (rec_wstrb !== 64'h20 || rec_wdata !== exp_wd || rec_awsize !== 3'b000) begin
            failures++; $display("FAIL sb_lane wstrb=%h size=%b exp wstrb=20 size=000", rec_wstrb, rec_awsize);
        end
        fill_line(); line[32*1 +: 32] = 32'h0BADF00D; rresp_cfg = 2'b10;
        sb_q.push_back('{1, 32'h0BADF00D, 1, 1});
        run_op(1, 0, 1, 31'h44, 32'h0, ok, rd, err, t0, ta);
        rresp_cfg = 2'b00;
        ex = sb_q.pop_front();
        checks++;
        if (!ok || rd !== ex.data || err !== ex.err) begin
            failures++; $display("FAIL lw_rerr ok=%b got=%h err=%b exp=%h err=1", ok, rd, err, ex.data);
        end
    endtask

    task automatic test_arbitration();
        bit ok, err, f_done, e_done; logic [31:0] rd; int t0, ta, first_cyc, second_cyc, n_ack;
        exp_t ex;
        // leave the last grant on exec so round-robin would favour fetch next
        fill_line();
        run_op(1, 0, 1, 31'h0, 32'h0, ok, rd, err, t0, ta);
        fill_line();
        line[31:0] = 32'h11111111; line[63:32] = 32'h22222222;
`ifdef ARB_RR_EN
        sb_q.push_back('{0, 32'h11111111, 1, 0});
        sb_q.push_back('{1, 32'h22222222, 1, 0});
`else
        sb_q.push_back('{1, 32'h22222222, 1, 0});
        sb_q.push_back('{0, 32'h11111111, 1, 0});
`endif
        @(negedge clk);
        f_req = 1; f_addr = 31'h100;
        e_req = 1; e_we = 0; e_size = 1; e_addr = 31'h104;
        t0 = cyc; f_done = 0; e_done = 0; n_ack = 0; first_cyc = 0; second_cyc = 0;
        for (int i = 0; i < 60 && !(f_done && e_done); i++) begin
            @(negedge clk);
            if (f_ack || e_ack) begin
                n_ack++;
                if (n_ack == 1) first_cyc = cyc; else second_cyc = cyc;
                if (sb_q.size() == 0) begin
                    checks++; failures++; $display("FAIL arb_extra_ack f=%b e=%b", f_ack, e_ack);
                end else begin
                    ex = sb_q.pop_front();
                    checks++;
                    if ({f_ack, e_ack} !== (ex.is_exec ? 2'b01 : 2'b10) ||
                        (ex.is_exec ? e_rdata : f_rdata) !== ex.data) begin
                        failures++; $display("FAIL arb_order%0d f_ack=%b e_ack=%b f=%h e=%h exp exec=%b data=%h",
                                             n_ack, f_ack, e_ack, f_rdata, e_rdata, ex.is_exec, ex.data);
                    end
                end
                if (f_ack) begin f_req = 0; f_done = 1; end
                if (e_ack) begin e_req = 0; e_done = 1; end
            end
        end
        f_req = 0; e_req = 0;
        checks++;
        if (!(f_done && e_done) || first_cyc - t0 !== 3 || second_cyc - first_cyc !== 4) begin
            failures++; $display("FAIL arb_timing done=%b%b first=%0d gap=%0d exp first=3 gap=4",
                                 f_done, e_done, first_cyc - t0, second_cyc - first_cyc);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok, err, seen; logic [31:0] rd; int t0, ta; exp_t ex;
        ar_wait = 20; seen = 0;
        @(negedge clk);
        f_req = 1; f_addr = 31'h100;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (arvalid) seen = 1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rst_mid_arvalid never asserted exp 1"); end
        rstn = 0;
        #1;
        checks++;
        if ({arvalid, rready, f_ack, e_ack, e_err} !== 5'b0) begin
            failures++; $display("FAIL rst_mid_async got=%b exp=00000", {arvalid, rready, f_ack, e_ack, e_err});
        end
        f_req = 0;
        repeat (2) @(negedge clk);
        rstn = 1; ar_wait = 0;
        fill_line(); line[31:0] = 32'hCAFEF00D;
        sb_q.push_back('{0, 32'hCAFEF00D, 1, 0});
        run_op(0, 0, 1, 31'h200, 32'h0, ok, rd, err, t0, ta);
        ex = sb_q.pop_front();
        checks++;
        if (!ok || rd !== ex.data || ta - t0 !== 3 || rec_araddr !== 31'h200) begin
            failures++; $display("FAIL rst_mid_recover ok=%b got=%h lat=%0d addr=%h exp %h lat=3 addr=200",
                                 ok, rd, ta - t0, rec_araddr, ex.data);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_exec_loads();
        test_store_word();
        test_errors();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
